// File: rtl/bit_scan16.sv
// rtl/bit_scan16.sv - decomposes a 16-bit mask into its set-bit indices, LSB first
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready     mask handshake; in_ready only while IDLE
//   in_mask               mask to decompose
//   out_valid/out_ready   index handshake; out_valid only while EMIT
//   out_index, out_last   lowest set bit of the remainder, and "final bit" flag
//   empty                 one-cycle pulse after a zero mask is accepted
//   set_count             popcount of the last accepted mask
//   busy                  high while EMIT

module bit_scan16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_mask,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_index,
    output logic             out_last,
    output logic             empty,
    output logic [4:0]       set_count,
    output logic             busy
);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] remainder;

    logic [4:0]       mask_pop;
    logic [3:0]       low_index;
    logic             single_bit;
    logic [WIDTH-1:0] remainder_cleared;

    always_comb begin
        mask_pop = 5'd0;
        for (int i = 0; i < WIDTH; i++) begin
            mask_pop = mask_pop + {4'd0, in_mask[i]};
        end
    end

    // Scan from the top down so the last hit written is the lowest set bit.
    always_comb begin
        low_index = 4'd0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (remainder[i]) begin
                low_index = i[3:0];
            end
        end
    end

    // x & (x - 1) drops the lowest set bit; a zero result means x had one bit.
    assign remainder_cleared = remainder & (remainder - WIDTH'(1));
    assign single_bit        = (remainder != '0) && (remainder_cleared == '0);

    assign in_ready  = (state == IDLE);
    assign busy      = (state == EMIT);
    assign out_valid = busy;
    assign out_index = busy ? low_index : 4'd0;
    assign out_last  = busy && single_bit;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            remainder <= '0;
            set_count <= 5'd0;
            empty     <= 1'b0;
        end else begin
            empty <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        remainder <= in_mask;
                        set_count <= mask_pop;
                        if (in_mask == '0) begin
                            empty <= 1'b1;
                        end else begin
                            state <= EMIT;
                        end
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        remainder <= remainder_cleared;
                        if (single_bit) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bit_scan16.sv
// tb/tb_bit_scan16.sv - directed self-checking bench for bit_scan16

module tb_bit_scan16;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_mask;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_index;
    logic        out_last;
    logic        empty;
    logic [4:0]  set_count;
    logic        busy;

    int checks = 0;
    int errors = 0;

    bit_scan16 #(.WIDTH(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mask   (in_mask),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_index (out_index),
        .out_last  (out_last),
        .empty     (empty),
        .set_count (set_count),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, " in_ready"},  32'(in_ready),  32'd1);
        check({tag, " out_valid"}, 32'(out_valid), 32'd0);
        check({tag, " out_index"}, 32'(out_index), 32'd0);
        check({tag, " out_last"},  32'(out_last),  32'd0);
        check({tag, " busy"},      32'(busy),      32'd0);
    endtask

    task automatic check_emit(input string tag, input int idx, input bit last);
        check({tag, " out_valid"}, 32'(out_valid), 32'd1);
        check({tag, " in_ready"},  32'(in_ready),  32'd0);
        check({tag, " out_index"}, 32'(out_index), 32'(idx));
        check({tag, " out_last"},  32'(out_last),  32'(last));
    endtask

    task automatic accept(input logic [15:0] mask);
        in_valid = 1'b1;
        in_mask  = mask;
        step();
        in_valid = 1'b0;
    endtask

    int idx_8421 [4] = '{0, 5, 10, 15};

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_mask   = 16'h0000;
        out_ready = 1'b0;
        step();
        step();
        reset = 1'b0;
        check_idle("reset");
        check("reset set_count", 32'(set_count), 32'd0);
        check("reset empty",     32'(empty),     32'd0);

        // reset beats a simultaneous input handshake
        reset    = 1'b1;
        in_valid = 1'b1;
        in_mask  = 16'h0003;
        step();
        reset    = 1'b0;
        in_valid = 1'b0;
        check_idle("rst_vs_in");
        check("rst_vs_in set_count", 32'(set_count), 32'd0);

        // 8421 with out_ready high: 0, 5, 10, 15 back to back
        out_ready = 1'b1;
        accept(16'h8421);
        check("8421 set_count", 32'(set_count), 32'd4);
        check("8421 busy",      32'(busy),      32'd1);
        for (int k = 0; k < 4; k++) begin
            check_emit($sformatf("8421[%0d]", k), idx_8421[k], k == 3);
            step();
        end
        check_idle("8421 done");
        check("8421 set_count hold", 32'(set_count), 32'd4);

        // zero mask: empty pulse only; a new mask accepted while empty is high
        accept(16'h0000);
        check("zero empty",     32'(empty),     32'd1);
        check("zero set_count", 32'(set_count), 32'd0);
        check_idle("zero");
        out_ready = 1'b0;
        accept(16'h0006);
        check("0006 empty",     32'(empty),     32'd0);
        check("0006 set_count", 32'(set_count), 32'd2);
        // index 1 held for 3 stalled cycles plus the handshake cycle
        for (int c = 0; c < 4; c++) begin
            check_emit($sformatf("0006 hold%0d", c), 1, 1'b0);
            if (c == 3) out_ready = 1'b1;
            step();
        end
        check_emit("0006 second", 2, 1'b1);
        step();
        check_idle("0006 done");

        // all ones: 0..15, last only on 15
        accept(16'hFFFF);
        check("FFFF set_count", 32'(set_count), 32'd16);
        for (int i = 0; i < 16; i++) begin
            check_emit($sformatf("FFFF[%0d]", i), i, i == 15);
            step();
        end
        check_idle("FFFF done");

        // reset mid-EMIT after index 5 is taken
        accept(16'h00F0);
        check_emit("00F0 first", 4, 1'b0);
        step();
        check_emit("00F0 second", 5, 1'b0);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_idle("00F0 rst");
        check("00F0 rst set_count", 32'(set_count), 32'd0);
        for (int c = 0; c < 3; c++) begin
            step();
            check($sformatf("00F0 no_emit%0d", c), 32'(out_valid), 32'd0);
        end

        // in_mask toggling while draining 0300 is ignored
        accept(16'h0300);
        in_valid = 1'b1;
        in_mask  = 16'hF00F;
        check_emit("0300 first", 8, 1'b0);
        step();
        in_mask = 16'h0001;
        check_emit("0300 second", 9, 1'b1);
        check("0300 set_count", 32'(set_count), 32'd2);
        step();
        check_idle("0300 gap");
        step();
        in_valid = 1'b0;
        check_emit("0001 idx", 0, 1'b1);
        check("0001 set_count", 32'(set_count), 32'd1);
        step();
        check_idle("0001 done");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
